// File: rtl/soft_mute_ramp.sv
// Soft mute: linear per-sample gain ramp on a 32-bit signed stereo stream.
// Define SOFT_MUTE_ZC_EN to defer ramp starts to an in_L zero crossing (or timeout).
module soft_mute_ramp #(
    parameter int unsigned GAIN_W     = 8,
    parameter int unsigned RAMP_STEP  = 16,
    parameter int unsigned ZC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [31:0] in_L,
    input  logic [31:0] in_R,
    output logic [31:0] out_L,
    output logic [31:0] out_R,
    output logic        out_valid,
    output logic        muted,
    output logic        ramping
);

    localparam int unsigned PW = 32 + GAIN_W + 1;
    localparam logic [GAIN_W:0] FULL = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] STEP = (GAIN_W + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {StUnmuted, StRampDown, StMuted, StRampUp} state_t;

    state_t          state_q, state_d;
    logic [GAIN_W:0] gain_q, gain_d;
    logic [GAIN_W:0] gain_down, gain_up;
    logic [31:0]     out_l_q, out_r_q;
    logic            out_valid_q;
    logic            pending, start_ok, move;
    logic [PW-1:0]   prod_l, prod_r;
    logic [31:0]     scaled_l, scaled_r;

`ifdef SOFT_MUTE_ZC_EN
    localparam int unsigned TO_W = $clog2(ZC_TIMEOUT + 1);
    logic            sign_q;
    logic [TO_W-1:0] wait_q, wait_next;
    logic            zc_hit;
`endif

    always_comb begin
        // Both operands widened to the full product width; gain is zero-extended.
        prod_l   = PW'($signed({{(GAIN_W + 1){in_L[31]}}, in_L}) * $signed({32'd0, gain_q}));
        prod_r   = PW'($signed({{(GAIN_W + 1){in_R[31]}}, in_R}) * $signed({32'd0, gain_q}));
        scaled_l = 32'($signed(prod_l) >>> GAIN_W);
        scaled_r = 32'($signed(prod_r) >>> GAIN_W);
    end

    always_comb begin
        pending = ((state_q == StUnmuted) && enable) || ((state_q == StMuted) && !enable);
`ifdef SOFT_MUTE_ZC_EN
        zc_hit    = in_L[31] ^ sign_q;
        wait_next = wait_q + 1'b1;
        start_ok  = zc_hit || (wait_next >= TO_W'(ZC_TIMEOUT));
`else
        start_ok = 1'b1;
`endif
        move = (state_q == StRampDown) || (state_q == StRampUp) || (pending && start_ok);

        gain_down = (gain_q < STEP) ? '0 : gain_q - STEP;
        gain_up   = (gain_q > FULL - STEP) ? FULL : gain_q + STEP;
        // Whenever the gain moves, enable alone picks the direction.
        gain_d    = enable ? gain_down : gain_up;

        if (gain_d == '0) begin
            state_d = StMuted;
        end else if (gain_d == FULL) begin
            state_d = StUnmuted;
        end else if (enable) begin
            state_d = StRampDown;
        end else begin
            state_d = StRampUp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StMuted;
            gain_q      <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef SOFT_MUTE_ZC_EN
            sign_q      <= 1'b0;
            wait_q      <= '0;
`endif
        end else begin
            out_valid_q <= sample_valid;
            if (sample_valid) begin
                out_l_q <= scaled_l;
                out_r_q <= scaled_r;
                if (move) begin
                    state_q <= state_d;
                    gain_q  <= gain_d;
                end
`ifdef SOFT_MUTE_ZC_EN
                sign_q <= in_L[31];
                wait_q <= (pending && !start_ok) ? wait_next : '0;
`endif
            end
        end
    end

    assign out_L     = out_l_q;
    assign out_R     = out_r_q;
    assign out_valid = out_valid_q;
    assign muted     = (state_q == StMuted);
    assign ramping   = (state_q == StRampDown) || (state_q == StRampUp);

endmodule

// File: doc/soft_mute_ramp.md
Name: soft_mute_ramp

Overview:
Clocked counterpart to the instant mute switch. It fades the stereo stream out when `enable` asserts and back in when `enable` deasserts, using a linear gain ramp applied per sample. This removes clicks at mute and unmute. It sits in the effect chain on the 32-bit signed L/R sample path, gated by a per-sample strobe.

Parameters:
GAIN_W, 8, gain fraction bits; unity gain FULL = 2**GAIN_W (256)
RAMP_STEP, 16, gain increment/decrement per accepted sample; ramp length = FULL/RAMP_STEP samples
ZC_TIMEOUT, 64, max samples to wait for a zero crossing (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  mute request (1 = mute, 0 = pass); already synchronised to clk upstream
sample_valid  input  1  one-cycle strobe; in_L/in_R are valid this cycle
in_L  input  32  signed left sample
in_R  input  32  signed right sample
out_L  output  32  signed scaled left sample, registered
out_R  output  32  signed scaled right sample, registered
out_valid  output  1  one-cycle strobe, 1 cycle after sample_valid
muted  output  1  high when state is MUTED (gain == 0)
ramping  output  1  high in RAMP_DOWN or RAMP_UP

Behaviour:
- Reset (async, active-high): gain=0, state=MUTED, out_L=out_R=0, out_valid=0, muted=1, ramping=0. Reset mid-ramp aborts immediately with the same values. After release, if enable=0, the block fades in from 0.
- Gain register: unsigned, range 0..FULL, width GAIN_W+1.
- States:
  - UNMUTED: gain=FULL.
  - RAMP_DOWN.
  - MUTED: gain=0.
  - RAMP_UP.
- All state and gain updates happen only on cycles with sample_valid=1. Between strobes, everything holds.
- UNMUTED & enable=1 -> RAMP_DOWN. MUTED & enable=0 -> RAMP_UP. Both transitions are subject to the optional feature.
- RAMP_DOWN: gain -= RAMP_STEP, clamped at 0. Enter MUTED on the sample where the new gain is 0. If enable=0 on any sample, go directly to RAMP_UP with gain += RAMP_STEP from the current value (no jump, no restart).
- RAMP_UP: gain += RAMP_STEP, clamped at FULL. Enter UNMUTED on the sample where the new gain is FULL. If enable=1, reverse to RAMP_DOWN the same way.
- Datapath: on a sample_valid cycle, out_X <= (in_X * gain) >>> GAIN_W.
  - Uses the gain value present in that cycle, before its update.
  - Full-precision signed product (32+GAIN_W+1 bits), arithmetic shift right, so rounding is toward -inf.
  - The result always fits in 32 bits because gain <= FULL. No saturation is needed.
  - At gain=FULL the output equals the input exactly; at gain=0 the output is 0.
- out_valid <= sample_valid (latency 1). out_L/out_R hold between strobes.
- muted/ramping are decoded from the registered state.
- Back-to-back sample_valid on every clock must be supported.
- RAMP_STEP that does not divide FULL: the clamp guarantees gain ends exactly at 0 or FULL.

Optional Feature:
Macro: SOFT_MUTE_ZC_EN.
- Defined: entry from UNMUTED into RAMP_DOWN, or from MUTED into RAMP_UP, is deferred until one of:
  - in_L changes sign (sign bit differs) between two consecutive accepted samples, or
  - ZC_TIMEOUT accepted samples have elapsed since the request first appeared.
  A counter counts the wait and clears when the request withdraws or the ramp starts. The ramp begins on the qualifying sample. Mid-ramp reversals remain immediate.
- Undefined: the ramp starts on the first accepted sample where the request differs from the state. There is no counter and no sign tracking.

Test Plan:
- Reset, enable=0, in_L=in_R=1000 each strobe:
  - outputs are 0, 62, 125, 187, ...;
  - the 17th output is 1000;
  - UNMUTED and ramping=0 after the 16th sample.
- Same sequence with in_L=-1000: second output is -63 (floor rounding check); final output is -1000.
- From UNMUTED, set enable=1, in=1000:
  - outputs are 1000, 937, 875, ...;
  - 0 from the 17th output onward;
  - muted=1.
- From UNMUTED, enable=1 for 5 samples (gain 176), then enable=0: next outputs use gain 176, 192, 208 (687, 750, 812). No discontinuity.
- Assert reset asynchronously mid-RAMP_UP between clock edges: out_L=out_R=0, out_valid=0, muted=1 immediately, without waiting for a clk edge.
- Unity/full-scale check at UNMUTED: in_L=0x7FFFFFFF, in_R=0x80000000 -> identical outputs. Also verify that gaps between strobes hold outputs and gain.
